mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_load_ext.sv | 38 +++
 rtl/mem_stage.sv | 70 +++++++
 tb/tb_mem_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - stall encoding, bus widths, load opcodes and bus layouts for mem_stage
package mem_stage_pkg;

    localparam int STALL_BUS_WD = 6;
    typedef logic [STALL_BUS_WD-1:0] stall_bus_t;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int EX_TO_MEM_BASE_WD = 76;
    localparam int MEM_TO_WB_BASE_WD = 70;
    localparam int DIV_WD            = 65;
    localparam int LOAD_OP_WD        = 3;
    localparam int EX_TO_MEM_WD      = EX_TO_MEM_BASE_WD + DIV_WD + LOAD_OP_WD;
    localparam int MEM_TO_WB_WD      = MEM_TO_WB_BASE_WD + DIV_WD;
    localparam int RF_FWD_WD         = 38;

    typedef enum logic [LOAD_OP_WD-1:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

    typedef struct packed {
        logic                  inst_div;
        logic [63:0]           div_result;
        logic [LOAD_OP_WD-1:0] load_op;
        logic [31:0]           pc;
        logic                  ram_en;
        logic [3:0]            ram_wen;
        logic                  sel_rf_res;
        logic                  rf_we;
        logic [4:0]            rf_waddr;
        logic [31:0]           ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic        inst_div;
        logic [63:0] div_result;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - selects and extends the byte/halfword/word of a load from SRAM read data
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  load_op_e    load_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halfword/word accesses are not trapped; only offset[1] picks the half.
    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        value = '0;
        case (load_op)
            LOAD_LB:  value = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: value = {24'd0, byte_sel};
            LOAD_LH:  value = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: value = {16'd0, half_sel};
            LOAD_LW:  value = rdata;
            default:  value = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: EX->MEM register, load data extraction, WB bus and decode bypass
// Optional decode bypass is enabled with macro MEM_STAGE_FWD_EN; otherwise mem_to_id_fwd is tied to 0.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STALL_IDX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [RF_FWD_WD-1:0]    mem_to_id_fwd
);

    ex_to_mem_t  ex_d;
    ex_to_mem_t  ex_q;
    mem_to_wb_t  wb;
    logic [31:0] load_value;
    logic        is_load;
    logic        stall_unused;

    assign stall_unused = ^stall;

    // Stalled here but not downstream: the next stage moves on, so insert a bubble.
    always_comb begin
        ex_d = ex_q;
        if (stall[STALL_IDX] == NO_STOP) begin
            ex_d = ex_to_mem_t'(ex_to_mem_bus);
        end else if (stall[STALL_IDX+1] == NO_STOP) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    mem_load_ext u_load_ext (
        .load_op (load_op_e'(ex_q.load_op)),
        .offset  (ex_q.ex_result[1:0]),
        .rdata   (data_sram_rdata),
        .value   (load_value)
    );

    assign is_load = ex_q.ram_en && (ex_q.ram_wen == 4'd0) && ex_q.sel_rf_res;

    always_comb begin
        wb.inst_div   = ex_q.inst_div;
        wb.div_result = ex_q.div_result;
        wb.pc         = ex_q.pc;
        wb.rf_we      = ex_q.rf_we && (ex_q.rf_waddr != 5'd0);
        wb.rf_waddr   = ex_q.rf_waddr;
        wb.rf_wdata   = is_load ? load_value : ex_q.ex_result;
    end

    assign mem_to_wb_bus = wb;

`ifdef MEM_STAGE_FWD_EN
    assign mem_to_id_fwd = {wb.rf_we, wb.rf_waddr, wb.rf_wdata};
`else
    assign mem_to_id_fwd = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a field-level reference model
module tb_mem_stage;

    localparam int SIDX = 3;

    typedef struct packed {
        logic        inst_div;
        logic [63:0] div_result;
        logic [2:0]  load_op;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] ex_result;
    } txn_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rd;
        logic [31:0] want;
    } load_vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [143:0] ex_bus;
    logic [31:0]  rdata;
    logic [134:0] wb_bus;
    logic [37:0]  fwd;

    int   n_checks = 0;
    int   n_fail = 0;
    txn_t model_q;

    mem_stage #(.STALL_IDX(SIDX)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .mem_to_id_fwd   (fwd)
    );

    always #5 clk = ~clk;

    function automatic logic [143:0] pack_txn(input txn_t t);
        return {t.inst_div, t.div_result, t.load_op, t.pc, t.ram_en, t.ram_wen,
                t.sel, t.we, t.waddr, t.ex_result};
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * off)) % 256;
        h = (rd >> (16 * (off / 2))) % 65536;
        case (op)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            3'd5:    return rd;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [134:0] expect_wb(input txn_t t, input logic [31:0] rd);
        logic [31:0] wdata;
        logic        we;
        if (t.ram_en && t.ram_wen == 4'd0 && t.sel) wdata = load_value(t.load_op, t.ex_result[1:0], rd);
        else                                        wdata = t.ex_result;
        we = t.we && (t.waddr != 5'd0);
        return {t.inst_div, t.div_result, t.pc, we, t.waddr, wdata};
    endfunction

    function automatic logic [37:0] expect_fwd(input txn_t t, input logic [31:0] rd);
        logic [134:0] w;
        w = expect_wb(t, rd);
`ifdef MEM_STAGE_FWD_EN
        return w[37:0];
`else
        return (w[0] & 1'b0) ? 38'h1 : 38'd0;
`endif
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.inst_div   = 1'($urandom_range(0, 1));
        t.div_result = {$urandom, $urandom};
        t.load_op    = 3'($urandom_range(0, 7));
        t.pc         = $urandom;
        t.ram_en     = ($urandom_range(0, 3) != 0);
        t.ram_wen    = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom);
        t.sel        = ($urandom_range(0, 3) != 0);
        t.we         = 1'($urandom_range(0, 1));
        t.waddr      = 5'($urandom_range(0, 31));
        t.ex_result  = $urandom;
        return t;
    endfunction

    function automatic txn_t simple_txn(input logic [2:0] op, input logic [31:0] addr,
                                        input logic [4:0] waddr, input logic is_ld);
        txn_t t;
        t = '0;
        t.load_op   = op;
        t.ram_en    = is_ld;
        t.sel       = is_ld;
        t.we        = 1'b1;
        t.waddr     = waddr;
        t.ex_result = addr;
        t.pc        = 32'hBFC0_0100;
        return t;
    endfunction

    task automatic clock_in(input txn_t t, input logic [5:0] st);
        ex_bus = pack_txn(t);
        stall  = st;
        @(posedge clk);
        if (!st[SIDX])        model_q = t;
        else if (!st[SIDX+1]) model_q = '0;
        #2;
    endtask

    task automatic test_reset();
        ex_bus = pack_txn(rand_txn());
        rdata  = 32'hDEAD_BEEF;
        stall  = 6'd0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (wb_bus !== 135'd0) begin
            n_fail++;
            $display("FAIL reset_wb: got %h expected 0", wb_bus);
        end
        n_checks++;
        if (fwd !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_fwd: got %h expected 0", fwd);
        end
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (wb_bus !== 135'd0) begin
            n_fail++;
            $display("FAIL reset_held_wb: got %h expected 0", wb_bus);
        end
        rst = 1'b0;
        model_q = '0;
    endtask

    task automatic test_loads();
        load_vec_t vecs[8];
        txn_t      t;
        vecs[0] = '{3'd1, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[1] = '{3'd2, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080};
        vecs[2] = '{3'd3, 32'h0000_1002, 32'h9ABC_0001, 32'hFFFF_9ABC};
        vecs[3] = '{3'd4, 32'h0000_1002, 32'h9ABC_0001, 32'h0000_9ABC};
        vecs[4] = '{3'd5, 32'h0000_1000, 32'h9ABC_0001, 32'h9ABC_0001};
        vecs[5] = '{3'd1, 32'h0000_1000, 32'h80FF_1234, 32'h0000_0034};
        vecs[6] = '{3'd3, 32'h0000_1001, 32'h9ABC_8001, 32'hFFFF_8001};
        vecs[7] = '{3'd5, 32'h0000_1003, 32'h1357_2468, 32'h1357_2468};
        for (int i = 0; i < 8; i++) begin
            t = simple_txn(vecs[i].op, vecs[i].addr, 5'd5, 1'b1);
            clock_in(t, 6'd0);
            rdata = vecs[i].rd;
            #1;
            n_checks++;
            if (wb_bus[31:0] !== vecs[i].want) begin
                n_fail++;
                $display("FAIL load_vec%0d_wdata: got %h expected %h", i, wb_bus[31:0], vecs[i].want);
            end
            n_checks++;
            if (fwd !== expect_fwd(t, vecs[i].rd)) begin
                n_fail++;
                $display("FAIL load_vec%0d_fwd: got %h expected %h", i, fwd, expect_fwd(t, vecs[i].rd));
            end
        end
    endtask

    task automatic test_passthrough();
        txn_t        t;
        logic [37:0] want_fwd;
        t = simple_txn(3'd1, 32'h1234_5678, 5'd8, 1'b0);
        clock_in(t, 6'd0);
        rdata = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (wb_bus[37:0] !== {1'b1, 5'd8, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL nonload_wb: got %h expected %h", wb_bus[37:0], {1'b1, 5'd8, 32'h1234_5678});
        end
`ifdef MEM_STAGE_FWD_EN
        want_fwd = {1'b1, 5'd8, 32'h1234_5678};
`else
        want_fwd = 38'd0;
`endif
        n_checks++;
        if (fwd !== want_fwd) begin
            n_fail++;
            $display("FAIL nonload_fwd: got %h expected %h", fwd, want_fwd);
        end
        t = simple_txn(3'd0, 32'h0000_00AA, 5'd0, 1'b0);
        t.inst_div   = 1'b1;
        t.div_result = 64'h0000_0003_0000_0007;
        clock_in(t, 6'd0);
        #1;
        n_checks++;
        if (wb_bus[37] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_waddr_we: got %b expected 0", wb_bus[37]);
        end
        n_checks++;
        if (wb_bus[134:70] !== {1'b1, 64'h0000_0003_0000_0007}) begin
            n_fail++;
            $display("FAIL div_pass: got %h expected %h", wb_bus[134:70], {1'b1, 64'h0000_0003_0000_0007});
        end
    endtask

    task automatic test_stall();
        txn_t ta;
        txn_t tb;
        ta = rand_txn();
        tb = rand_txn();
        ta.ex_result = ta.ex_result ^ 32'h5555_0000;
        tb.ex_result = ~ta.ex_result;
        clock_in(ta, 6'd0);
        rdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            clock_in(tb, 6'b011111);
            #1;
            n_checks++;
            if (wb_bus !== expect_wb(ta, rdata)) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, wb_bus, expect_wb(ta, rdata));
            end
        end
        clock_in(tb, 6'd0);
        #1;
        n_checks++;
        if (wb_bus !== expect_wb(tb, rdata)) begin
            n_fail++;
            $display("FAIL stall_release: got %h expected %h", wb_bus, expect_wb(tb, rdata));
        end
        clock_in(ta, 6'b001111);
        #1;
        n_checks++;
        if (wb_bus !== 135'd0) begin
            n_fail++;
            $display("FAIL stall_bubble: got %h expected 0", wb_bus);
        end
    endtask

    task automatic test_async_reset();
        txn_t t;
        txn_t t2;
        t  = simple_txn(3'd0, 32'hCAFE_F00D, 5'd9, 1'b0);
        t2 = simple_txn(3'd0, 32'h0BAD_CAFE, 5'd12, 1'b0);
        clock_in(t, 6'd0);
        rdata = 32'h0;
        #1;
        n_checks++;
        if (wb_bus !== expect_wb(t, rdata)) begin
            n_fail++;
            $display("FAIL areset_pre: got %h expected %h", wb_bus, expect_wb(t, rdata));
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (wb_bus !== 135'd0 || fwd !== 38'd0) begin
            n_fail++;
            $display("FAIL areset_mid: got wb %h fwd %h expected 0", wb_bus, fwd);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_q = '0;
        n_checks++;
        if (wb_bus !== 135'd0) begin
            n_fail++;
            $display("FAIL areset_hold: got %h expected 0", wb_bus);
        end
        clock_in(t2, 6'd0);
        #1;
        n_checks++;
        if (wb_bus !== expect_wb(t2, rdata)) begin
            n_fail++;
            $display("FAIL areset_resume: got %h expected %h", wb_bus, expect_wb(t2, rdata));
        end
    endtask

    task automatic test_random();
        txn_t       t;
        logic [5:0] st;
        for (int i = 0; i < 300; i++) begin
            t  = rand_txn();
            st = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            clock_in(t, st);
            rdata = $urandom;
            #1;
            n_checks++;
            if (wb_bus !== expect_wb(model_q, rdata)) begin
                n_fail++;
                $display("FAIL random%0d_wb: got %h expected %h", i, wb_bus, expect_wb(model_q, rdata));
            end
            n_checks++;
            if (fwd !== expect_fwd(model_q, rdata)) begin
                n_fail++;
                $display("FAIL random%0d_fwd: got %h expected %h", i, fwd, expect_fwd(model_q, rdata));
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        stall   = 6'd0;
        ex_bus  = '0;
        rdata   = '0;
        model_q = '0;
        test_reset();
        test_loads();
        test_passthrough();
        test_stall();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
